imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, two-stage pipelined RV immediate generator with valid/ready handshake, for the decode path of the pipelined core.
- Stage 1 decodes the instruction format and builds the sign-extended immediate at width XLEN.
- Stage 2 computes the PC-relative target (pc+imm or pc+4) and flags illegal opcodes.
- Supports stall through backpressure, and flush for branch redirect.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates sign-extend to XLEN; at 64, OP-IMM-32/OP-32 opcodes are legal.
- PC_INC, 4, PC increment used for the non-relative target.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  drop all in-flight entries
- in_valid  in  1  input entry valid
- in_ready  out  1  block can accept an entry this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of the instruction
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts the output
- out_imm  out  XLEN  immediate
- out_fmt  out  3  format code (see package)
- out_target  out  XLEN  computed target
- out_illegal  out  1  unsupported or illegal opcode

Behaviour:
- Reset (rst=0 at posedge clk): s1_valid=0, s2_valid=0, out_valid=0, out_imm=0, out_target=0, out_fmt=FMT_NONE, out_illegal=0. Reset dominates flush and in_valid.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !s1_valid || s2_free, where s2_free = !s2_valid || out_ready.
  - in_ready is purely combinational; no path from in_valid to in_ready.
- Latency: exactly 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, all outputs hold stable. Stage 1 holds its entry; with stage 1 full, in_ready=0.
- Flush: on flush=1, s1_valid and s2_valid clear at the next edge. An input presented in the same cycle is dropped. Output data registers keep stale values; out_valid=0.
- Format selection, from opcode in_instr[6:0]; instr[1:0]!=2'b11 gives fmt NONE, imm 0, illegal=1:
  - 00100, 00000, 11001 -> I: imm = sext(instr[31:20]).
  - 01000 -> S: imm = sext({instr[31:25], instr[11:7]}).
  - 11000 -> B: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 01101, 00101 -> U: imm = sext({instr[31:12], 12'b0}). At XLEN=64 the upper 32 bits copy bit 31.
  - 11011 -> J: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 00110 -> I, only when XLEN=64; otherwise illegal.
  - 01100, 00011, 11100 -> NONE, imm 0, legal.
  - 01110 -> NONE, legal only when XLEN=64.
  - Any other opcode -> NONE, imm 0, illegal=1.
- Target, computed in stage 2 with modulo-2^XLEN wrap and no overflow flag:
  - B, J, auipc (00101): target = pc + imm.
  - All other opcodes, including jalr: target = pc + PC_INC.
- Simultaneous input and output transfers in the same cycle must sustain full throughput with no bubble.

Optional Feature:
- Macro: IMMGEN_ZICSR_EN.
- When defined, opcode 11100 with funct3!=0 decodes as follows:
  - funct3[2]=1 -> fmt Z, imm = zero-extended instr[19:15] (zimm).
  - funct3[2]=0 -> fmt CSR, imm = zero-extended instr[31:20].
- When undefined, all 11100 encodings give fmt NONE, imm 0, legal.

Decomposition:
- Package imm_gen_pkg holds:
  - fmt enum, 3 bits: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6, FMT_CSR=7.
  - Opcode constants: OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM, OPC_MISCMEM, OPC_OPIMM32, OPC_OP32.
- One combinational sub-module, imm_decode, maps instruction to {fmt, imm, illegal}. Stage registers and the handshake stay in the top module.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), pc 0x0 -> after 2 cycles: imm 0xFFFFFFFF, fmt I, target 0x4, illegal 0.
- Stream of 0xFE112E23 (sw x1,-4(x2)) then 0xFE000CE3 (beq, pc 0x100), back-to-back with out_ready=1:
  - First output: imm 0xFFFFFFFC, fmt S.
  - Second output: imm 0xFFFFFFF8, fmt B, target 0xF8.
  - Consecutive out_valid cycles, no bubble.
- 0x123452B7 (lui x5,0x12345) with out_ready=0 for 3 cycles:
  - out_imm 0x12345000 held stable throughout.
  - in_ready=0 once stage 1 is full.
  - Entry released on the first cycle with out_ready=1.
- Two entries in flight, then flush=1 with in_valid=1 -> next cycle out_valid=0, s1 empty, the third input dropped.
- 0x00000000 and 0x0000007F -> illegal=1, fmt NONE, imm 0.
- Mid-stream rst=0 -> all valids 0 and outputs at reset values next edge.
- XLEN=64 run:
  - lui 0x800002B7 -> imm 0xFFFFFFFF80000000.
  - 0x0000001B (OP-IMM-32) -> legal.
- With IMMGEN_ZICSR_EN, 0x3400D073 (csrrwi, zimm=1) -> fmt Z, imm 0x1.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types and constants for the pipelined RV immediate generator.
//   fmt_e     - 3-bit immediate format code carried on out_fmt
//   OPC_*     - full 7-bit RV opcodes (instr[6:0]) recognised by the decoder
//   is_pc_rel - opcodes whose target is pc + imm rather than pc + PC_INC
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_CSR  = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // jalr is deliberately absent: its target is register-relative, so the
  // pipeline reports the fall-through pc + PC_INC for it.
  function automatic logic is_pc_rel(input logic [6:0] opcode);
    return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// imm_decode: combinational RV instruction -> {format, sign-extended immediate, illegal}.
//   instr   in  32    instruction word
//   fmt     out 3     format code (imm_gen_pkg::fmt_e)
//   imm     out XLEN  immediate, sign-extended (zero-extended for Z/CSR)
//   illegal out 1     opcode unsupported at this XLEN or malformed
// Build option: define IMMGEN_ZICSR_EN to decode SYSTEM CSR forms (fmt Z / CSR).
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam bit IsRv64 = (XLEN == 64);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  fmt_e            fmt_d;

  // Size casts of signed operands sign-extend to XLEN.
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  always_comb begin
    fmt_d   = FMT_NONE;
    imm     = '0;
    illegal = 1'b0;
    // Matching all 7 bits means instr[1:0] != 2'b11 falls to the default.
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        fmt_d = FMT_I;
        imm   = imm_i;
      end
      OPC_STORE: begin
        fmt_d = FMT_S;
        imm   = imm_s;
      end
      OPC_BRANCH: begin
        fmt_d = FMT_B;
        imm   = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_d = FMT_U;
        imm   = imm_u;
      end
      OPC_JAL: begin
        fmt_d = FMT_J;
        imm   = imm_j;
      end
      OPC_OPIMM32: begin
        if (IsRv64) begin
          fmt_d = FMT_I;
          imm   = imm_i;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP, OPC_MISCMEM: begin
      end
      OPC_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
        // funct3 == 0 covers ecall/ebreak/xret, which carry no immediate.
        if (instr[14:12] != 3'b000) begin
          if (instr[14]) begin
            fmt_d = FMT_Z;
            imm   = XLEN'(instr[19:15]);
          end else begin
            fmt_d = FMT_CSR;
            imm   = XLEN'(instr[31:20]);
          end
        end
`endif
      end
      OPC_OP32: begin
        illegal = !IsRv64;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign fmt = fmt_d;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage pipelined RV immediate generator with valid/ready handshake.
//   Stage 1 registers the decoded format/immediate; stage 2 (output registers)
//   holds the immediate plus the computed target (pc+imm or pc+PC_INC).
//   clk, rst (sync, active-low), flush (drop all in-flight entries)
//   in_valid/in_ready/in_instr/in_pc        input handshake and payload
//   out_valid/out_ready                     output handshake
//   out_imm/out_fmt/out_target/out_illegal  output payload
// Parameters: XLEN (32 or 64), PC_INC (fall-through increment).
// Build option: define IMMGEN_ZICSR_EN to decode SYSTEM CSR forms (fmt Z / CSR).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_INC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  imm_decode #(
    .XLEN (XLEN)
  ) u_imm_decode (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  logic            s1_valid_q, s1_valid_d;
  logic [2:0]      s1_fmt_q;
  logic [XLEN-1:0] s1_imm_q;
  logic            s1_illegal_q;
  logic [XLEN-1:0] s1_pc_q;
  logic            s1_rel_q;

  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] out_imm_q;
  logic [2:0]      out_fmt_q;
  logic [XLEN-1:0] out_target_q;
  logic            out_illegal_q;

  logic            s2_free, in_fire, s1_adv, s1_load, s2_load;
  logic [XLEN-1:0] target_d;

  // Stage 2 can take a new entry if empty or draining this cycle, which lets
  // simultaneous input and output transfers run at full throughput.
  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  // Flush only clears valids; data registers are simply not updated.
  assign s1_load  = in_fire && !flush;
  assign s2_load  = s1_adv && !flush;

  assign target_d = s1_rel_q ? (s1_pc_q + s1_imm_q) : (s1_pc_q + XLEN'(PC_INC));

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s2_free) s1_valid_d = 1'b0;
    if (in_fire) s1_valid_d = 1'b1;
    if (flush)   s1_valid_d = 1'b0;

    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
    if (flush) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q    <= 1'b0;
      s1_fmt_q      <= FMT_NONE;
      s1_imm_q      <= '0;
      s1_illegal_q  <= 1'b0;
      s1_pc_q       <= '0;
      s1_rel_q      <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_imm_q     <= '0;
      out_fmt_q     <= FMT_NONE;
      out_target_q  <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_fmt_q     <= dec_fmt;
        s1_imm_q     <= dec_imm;
        s1_illegal_q <= dec_illegal;
        s1_pc_q      <= in_pc;
        s1_rel_q     <= is_pc_rel(in_instr[6:0]);
      end
      if (s2_load) begin
        out_imm_q     <= s1_imm_q;
        out_fmt_q     <= s1_fmt_q;
        out_target_q  <= target_d;
        out_illegal_q <= s1_illegal_q;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_target  = out_target_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: reset values, a table of decode vectors
// (XLEN=32 and XLEN=64 instances), directed handshake sequences, and a
// randomized stream compared against a queue-based reference model.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_target;
  logic [2:0]  out_fmt;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_illegal_w, flush_w;
  logic [31:0] in_instr_w;
  logic [63:0] in_pc_w, out_imm_w, out_target_w;
  logic [2:0]  out_fmt_w;

  imm_gen_pipe #(.XLEN(32), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .PC_INC(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush_w),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_instr(in_instr_w), .in_pc(in_pc_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_imm(out_imm_w),
    .out_fmt(out_fmt_w), .out_target(out_target_w), .out_illegal(out_illegal_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
    logic [63:0] tgt;
  } res_t;

  // Reference: RV immediate rules written as arithmetic on a sign-extended word.
  function automatic res_t ref_model(input logic [31:0] ins, input logic [63:0] pc,
                                     input bit x64);
    res_t   r;
    longint s;
    bit     rel;
    s     = longint'($signed(ins));
    r.fmt = 3'd0;
    r.imm = 64'd0;
    r.ill = 1'b0;
    rel   = 1'b0;
    if (ins[1:0] != 2'b11) r.ill = 1'b1;
    else begin
      case (ins[6:2])
        5'b00100, 5'b00000, 5'b11001: begin r.fmt = 3'd1; r.imm = 64'(s >>> 20); end
        5'b01000: begin
          r.fmt = 3'd2;
          r.imm = 64'((s >>> 25) <<< 5) | 64'(ins[11:7]);
        end
        5'b11000: begin
          r.fmt = 3'd3; rel = 1'b1;
          r.imm = 64'((s >>> 31) <<< 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                | (64'(ins[11:8]) << 1);
        end
        5'b01101: begin r.fmt = 3'd4; r.imm = 64'(s) & ~64'hFFF; end
        5'b00101: begin r.fmt = 3'd4; r.imm = 64'(s) & ~64'hFFF; rel = 1'b1; end
        5'b11011: begin
          r.fmt = 3'd5; rel = 1'b1;
          r.imm = 64'((s >>> 31) <<< 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                | (64'(ins[30:21]) << 1);
        end
        5'b00110: begin
          if (x64) begin r.fmt = 3'd1; r.imm = 64'(s >>> 20); end
          else r.ill = 1'b1;
        end
        5'b01100, 5'b00011: ;
        5'b11100: begin
`ifdef IMMGEN_ZICSR_EN
          if (ins[14:12] != 3'd0) begin
            if (ins[14]) begin r.fmt = 3'd6; r.imm = 64'(ins[19:15]); end
            else         begin r.fmt = 3'd7; r.imm = 64'(ins[31:20]); end
          end
`endif
        end
        5'b01110: r.ill = !x64;
        default:  r.ill = 1'b1;
      endcase
    end
    r.tgt = pc + (rel ? r.imm : 64'd4);
    if (!x64) begin
      r.imm = r.imm & 64'hFFFF_FFFF;
      r.tgt = r.tgt & 64'hFFFF_FFFF;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37,
                             7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 12)];
    return w;
  endfunction

  // Scoreboard on the 32-bit instance: entries currently in the pipe, oldest first.
  res_t sb[$];

  always @(negedge clk) begin
    if (rst !== 1'b1) sb.delete();
    else begin
      check("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
      if (out_valid) begin
        if (sb.size() == 0) check("out_valid_empty", 64'(out_valid), 64'd0);
        else begin
          check("sb_imm", 64'(out_imm), sb[0].imm);
          check("sb_fmt", 64'(out_fmt), 64'(sb[0].fmt));
          check("sb_target", 64'(out_target), sb[0].tgt);
          check("sb_illegal", 64'(out_illegal), 64'(sb[0].ill));
        end
      end
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(ref_model(in_instr, 64'(in_pc), 1'b0));
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        ill;
    bit          x64;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] pc,
                              input logic [63:0] imm, input fmt_e fmt,
                              input logic [63:0] tgt, input logic ill, input bit x64);
    vec_t v;
    v.instr = instr; v.pc = pc; v.imm = imm; v.fmt = fmt;
    v.tgt = tgt; v.ill = ill; v.x64 = x64;
    return v;
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    flush_w = 1'b0; in_valid_w = 1'b0; in_instr_w = '0; in_pc_w = '0; out_ready_w = 1'b1;
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_target", 64'(out_target), 64'd0);
    check("rst_out_fmt", 64'(out_fmt), 64'(FMT_NONE));
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    check("rst64_out_valid", 64'(out_valid_w), 64'd0);
    check("rst64_out_imm", out_imm_w, 64'd0);
    rst = 1'b1;

    // Decode table: instr, pc, imm, fmt, target, illegal, xlen64.
    vecs.push_back(mk(32'hFFF00093, 64'h0,    64'hFFFFFFFF, FMT_I,    64'h4,    1'b0, 0));
    vecs.push_back(mk(32'hFE112E23, 64'h200,  64'hFFFFFFFC, FMT_S,    64'h204,  1'b0, 0));
    vecs.push_back(mk(32'hFE000CE3, 64'h100,  64'hFFFFFFF8, FMT_B,    64'hF8,   1'b0, 0));
    vecs.push_back(mk(32'h123452B7, 64'h10,   64'h12345000, FMT_U,    64'h14,   1'b0, 0));
    vecs.push_back(mk(32'h00000000, 64'h20,   64'h0,        FMT_NONE, 64'h24,   1'b1, 0));
    vecs.push_back(mk(32'h0000007F, 64'h30,   64'h0,        FMT_NONE, 64'h34,   1'b1, 0));
    vecs.push_back(mk(32'h00001297, 64'h1000, 64'h1000,     FMT_U,    64'h2000, 1'b0, 0));
    vecs.push_back(mk(32'hFFFFF017, 64'h1000, 64'hFFFFF000, FMT_U,    64'h0,    1'b0, 0));
    vecs.push_back(mk(32'h008000EF, 64'h40,   64'h8,        FMT_J,    64'h48,   1'b0, 0));
    vecs.push_back(mk(32'hFFC08067, 64'h50,   64'hFFFFFFFC, FMT_I,    64'h54,   1'b0, 0));
    vecs.push_back(mk(32'h0000001B, 64'h60,   64'h0,        FMT_NONE, 64'h64,   1'b1, 0));
    vecs.push_back(mk(32'h00000033, 64'h70,   64'h0,        FMT_NONE, 64'h74,   1'b0, 0));
    vecs.push_back(mk(32'h0000003B, 64'h78,   64'h0,        FMT_NONE, 64'h7C,   1'b1, 0));
    vecs.push_back(mk(32'h80002003, 64'h90,   64'hFFFFF800, FMT_I,    64'h94,   1'b0, 0));
    vecs.push_back(mk(32'h00000013, 64'hFFFFFFFC, 64'h0,    FMT_I,    64'h0,    1'b0, 0));
    vecs.push_back(mk(32'h00000073, 64'hA0,   64'h0,        FMT_NONE, 64'hA4,   1'b0, 0));
`ifdef IMMGEN_ZICSR_EN
    vecs.push_back(mk(32'h3400D073, 64'h80,   64'h1,        FMT_Z,    64'h84,   1'b0, 0));
    vecs.push_back(mk(32'h34001073, 64'h88,   64'h340,      FMT_CSR,  64'h8C,   1'b0, 0));
`else
    vecs.push_back(mk(32'h3400D073, 64'h80,   64'h0,        FMT_NONE, 64'h84,   1'b0, 0));
    vecs.push_back(mk(32'h34001073, 64'h88,   64'h0,        FMT_NONE, 64'h8C,   1'b0, 0));
`endif
    vecs.push_back(mk(32'h800002B7, 64'h0,  64'hFFFFFFFF80000000, FMT_U, 64'h4, 1'b0, 1));
    vecs.push_back(mk(32'h0000001B, 64'h10, 64'h0, FMT_I, 64'h14, 1'b0, 1));
    vecs.push_back(mk(32'h0000003B, 64'h20, 64'h0, FMT_NONE, 64'h24, 1'b0, 1));
    vecs.push_back(mk(32'hFFF00093, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFF, FMT_I,
                      64'h0, 1'b0, 1));
    vecs.push_back(mk(32'hFE000CE3, 64'h100, 64'hFFFFFFFFFFFFFFF8, FMT_B, 64'hF8, 1'b0, 1));

    foreach (vecs[i]) begin
      if (!vecs[i].x64) begin
        in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc[31:0];
        step();
        in_valid = 1'b0;
        step();
        check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
        check($sformatf("v%0d_imm", i), 64'(out_imm), vecs[i].imm);
        check($sformatf("v%0d_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
        check($sformatf("v%0d_target", i), 64'(out_target), vecs[i].tgt);
        check($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
      end else begin
        in_valid_w = 1'b1; in_instr_w = vecs[i].instr; in_pc_w = vecs[i].pc;
        step();
        in_valid_w = 1'b0;
        step();
        check($sformatf("v%0d_valid64", i), 64'(out_valid_w), 64'd1);
        check($sformatf("v%0d_imm64", i), out_imm_w, vecs[i].imm);
        check($sformatf("v%0d_fmt64", i), 64'(out_fmt_w), 64'(vecs[i].fmt));
        check($sformatf("v%0d_target64", i), out_target_w, vecs[i].tgt);
        check($sformatf("v%0d_illegal64", i), 64'(out_illegal_w), 64'(vecs[i].ill));
      end
    end
    step();

    // Back-to-back sw then beq: consecutive outputs, no bubble.
    in_valid = 1'b1; in_instr = 32'hFE112E23; in_pc = 32'h200;
    step();
    in_instr = 32'hFE000CE3; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    check("b2b_first_valid", 64'(out_valid), 64'd1);
    check("b2b_first_imm", 64'(out_imm), 64'hFFFFFFFC);
    check("b2b_first_fmt", 64'(out_fmt), 64'(FMT_S));
    step();
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_imm", 64'(out_imm), 64'hFFFFFFF8);
    check("b2b_second_fmt", 64'(out_fmt), 64'(FMT_B));
    check("b2b_second_target", 64'(out_target), 64'hF8);
    step();
    check("b2b_drained", 64'(out_valid), 64'd0);

    // lui stalled by out_ready=0, with a second entry filling stage 1.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h10;
    step();
    in_valid = 1'b0;
    step();
    check("stall_valid0", 64'(out_valid), 64'd1);
    check("stall_imm0", 64'(out_imm), 64'h12345000);
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h0;
    step();
    in_valid = 1'b0;
    check("stall_imm1", 64'(out_imm), 64'h12345000);
    check("stall_in_ready1", 64'(in_ready), 64'd0);
    step();
    check("stall_imm2", 64'(out_imm), 64'h12345000);
    check("stall_valid2", 64'(out_valid), 64'd1);
    check("stall_in_ready2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", 64'(in_ready), 64'd1);
    step();
    check("stall_next_valid", 64'(out_valid), 64'd1);
    check("stall_next_imm", 64'(out_imm), 64'hFFFFFFFF);
    step();
    check("stall_done", 64'(out_valid), 64'd0);

    // Two in flight, then flush with a third input offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h0;
    step();
    in_instr = 32'h123452B7; in_pc = 32'h10;
    step();
    check("flush_pre_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1; in_instr = 32'h008000EF; in_pc = 32'h40;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid0", 64'(out_valid), 64'd0);
    step();
    check("flush_valid1", 64'(out_valid), 64'd0);
    step();
    check("flush_valid2", 64'(out_valid), 64'd0);

    // Mid-stream reset with input still offered.
    in_valid = 1'b1; in_instr = 32'hFE000CE3; in_pc = 32'h100;
    step();
    step();
    rst = 1'b0;
    step();
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_imm", 64'(out_imm), 64'd0);
    check("mrst_target", 64'(out_target), 64'd0);
    check("mrst_fmt", 64'(out_fmt), 64'(FMT_NONE));
    check("mrst_illegal", 64'(out_illegal), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    step();
    check("mrst_hold_valid", 64'(out_valid), 64'd0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    check("mrst_after_valid", 64'(out_valid), 64'd0);

    // Randomized stream against the scoreboard.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    check("drain_empty", 64'(sb.size()), 64'd0);
    step();
    check("drain_out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
